// File: rtl/motoro3_pwm_capture.sv
// PWM pulse capture: synchronizes and glitch-filters an asynchronous PWM input,
// then measures high time and rising-to-rising period in clock cycles.
module motoro3_pwm_capture #(
  parameter int          CNT_W    = 16,
  parameter int          FILT_LEN = 3,
  parameter int unsigned TIMEOUT  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             pwmIn,
  input  logic             m3r_capEnable,
  output logic [CNT_W-1:0] capHighLen,
  output logic [CNT_W-1:0] capPeriodLen,
  output logic             capValid,
  output logic             capOverflow,
  output logic             capStuck,
  output logic             capStuckLevel,
  output logic [1:0]       o_dbg_state
);

  localparam logic [CNT_W-1:0] TO_V      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       FILT_LAST = 4'(FILT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_STUCK = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_pwm_f;
  logic             r_pwm_f_d;
  logic [3:0]       r_filt_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_period_cnt;
  logic             w_rise;
  logic             w_fall;
  logic             w_timeout;
  logic             w_capture;
  logic             w_start;
  logic             w_stuck_set;
  logic             w_inc_high;
  logic             w_inc_period;
  logic             w_clear;

  // The filtered level flips only after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_pwm_f    <= 1'b0;
      r_pwm_f_d  <= 1'b0;
      r_filt_cnt <= '0;
    end else begin
      r_sync1   <= pwmIn;
      r_sync2   <= r_sync1;
      r_pwm_f_d <= r_pwm_f;
      if (r_sync2 != r_pwm_f) begin
        if (r_filt_cnt == FILT_LAST) begin
          r_pwm_f    <= r_sync2;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 4'd1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_rise      = r_pwm_f & ~r_pwm_f_d;
  assign w_fall      = ~r_pwm_f & r_pwm_f_d;
  assign w_timeout   = (r_period_cnt == TO_V);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // A rise beats the timeout, and the timeout beats a fall, in the same cycle.
  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_start      = 1'b0;
    w_stuck_set  = 1'b0;
    w_inc_high   = 1'b0;
    w_inc_period = 1'b0;
    w_clear      = 1'b0;
    if (!m3r_capEnable) begin
      w_next  = S_IDLE;
      w_clear = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_STUCK: begin
          if (w_rise) begin
            w_next  = S_HIGH;
            w_start = 1'b1;
          end
        end
        S_HIGH, S_LOW: begin
          if (w_rise) begin
            w_next    = S_HIGH;
            w_start   = 1'b1;
            w_capture = (r_state == S_LOW);
          end else if (w_timeout) begin
            w_next      = S_STUCK;
            w_stuck_set = 1'b1;
          end else begin
            w_inc_period = 1'b1;
            w_inc_high   = (r_state == S_HIGH) & ~w_fall;
            if ((r_state == S_HIGH) && w_fall) w_next = S_LOW;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
    end else if (w_clear) begin
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
    end else if (w_start) begin
      r_high_cnt   <= CNT_ONE;
      r_period_cnt <= CNT_ONE;
    end else begin
      if (w_inc_period && (r_period_cnt != CNT_MAX)) r_period_cnt <= r_period_cnt + CNT_ONE;
      if (w_inc_high && (r_high_cnt != CNT_MAX))     r_high_cnt   <= r_high_cnt + CNT_ONE;
    end
  end

  // Measurement registers keep their last values while capture is disabled.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      capHighLen    <= '0;
      capPeriodLen  <= '0;
      capValid      <= 1'b0;
      capOverflow   <= 1'b0;
      capStuck      <= 1'b0;
      capStuckLevel <= 1'b0;
    end else begin
      capValid <= w_capture;
      if (w_capture) begin
        capHighLen   <= r_high_cnt;
        capPeriodLen <= r_period_cnt;
        capOverflow  <= (r_high_cnt == CNT_MAX) | (r_period_cnt == CNT_MAX);
      end
      if (w_clear | w_start) begin
        capStuck <= 1'b0;
      end else if (w_stuck_set) begin
        capStuck      <= 1'b1;
        capStuckLevel <= r_pwm_f;
      end
    end
  end

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Bench for motoro3_pwm_capture: two instances (16-bit/TIMEOUT 1000 and 8-bit/TIMEOUT 255)
// checked every cycle against a timestamp-based model of the filtered edges.
module tb_motoro3_pwm_capture;

  localparam int FILT = 3;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        pwmIn = 1'b0;
  logic        en = 1'b1;

  logic [15:0] hi16, per16;
  logic        v16, ov16, st16, lv16;
  logic [1:0]  dbg16;
  logic [7:0]  hi8, per8;
  logic        v8, ov8, st8, lv8;
  logic [1:0]  dbg8;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  motoro3_pwm_capture #(.CNT_W(16), .FILT_LEN(FILT), .TIMEOUT(1000)) u_dut16 (
    .clk(clk), .nRst(nRst), .pwmIn(pwmIn), .m3r_capEnable(en),
    .capHighLen(hi16), .capPeriodLen(per16), .capValid(v16), .capOverflow(ov16),
    .capStuck(st16), .capStuckLevel(lv16), .o_dbg_state(dbg16)
  );

  motoro3_pwm_capture #(.CNT_W(8), .FILT_LEN(FILT), .TIMEOUT(255)) u_dut8 (
    .clk(clk), .nRst(nRst), .pwmIn(pwmIn), .m3r_capEnable(en),
    .capHighLen(hi8), .capPeriodLen(per8), .capValid(v8), .capOverflow(ov8),
    .capStuck(st8), .capStuckLevel(lv8), .o_dbg_state(dbg8)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Model: input delay line + run-length filter, then measurements from edge timestamps.
  int   cyc;
  logic m_in1, m_in2, m_f, m_fd;
  int   m_run;
  bit   trk[2], fseen[2];
  int   r_k[2], f_k[2];
  int   e_high[2], e_per[2];
  bit   e_valid[2], e_ov[2], e_stuck[2], e_lvl[2];

  task automatic model_step();
    logic rise, fall, old_f, pwm_s;
    if (!nRst) begin
      cyc = 0; m_in1 = 0; m_in2 = 0; m_f = 0; m_fd = 0; m_run = 0;
      for (int i = 0; i < 2; i++) begin
        trk[i] = 0; fseen[i] = 0; r_k[i] = 0; f_k[i] = 0;
        e_high[i] = 0; e_per[i] = 0; e_valid[i] = 0; e_ov[i] = 0;
        e_stuck[i] = 0; e_lvl[i] = 0;
      end
    end else begin
      cyc++;
      rise  = m_f & ~m_fd;
      fall  = ~m_f & m_fd;
      old_f = m_f;
      pwm_s = m_in2;
      m_in2 = m_in1;
      m_in1 = pwmIn;
      m_fd  = m_f;
      if (pwm_s != m_f) begin
        m_run++;
        if (m_run == FILT) begin
          m_f   = pwm_s;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      for (int i = 0; i < 2; i++) begin
        int mx, to, h, p;
        mx = (i == 0) ? 65535 : 255;
        to = (i == 0) ? 1000 : 255;
        e_valid[i] = 0;
        if (!en) begin
          trk[i] = 0;
          e_stuck[i] = 0;
        end else if (rise) begin
          if (trk[i] && fseen[i]) begin
            h = f_k[i] - r_k[i];
            p = cyc - r_k[i];
            if (h > mx) h = mx;
            if (p > mx) p = mx;
            e_high[i] = h;
            e_per[i] = p;
            e_ov[i] = (h == mx) || (p == mx);
            e_valid[i] = 1;
          end
          trk[i] = 1; r_k[i] = cyc; fseen[i] = 0; e_stuck[i] = 0;
        end else if (trk[i] && (cyc - r_k[i] == to)) begin
          e_stuck[i] = 1;
          e_lvl[i] = old_f;
          trk[i] = 0;
        end else if (trk[i] && fall && !fseen[i]) begin
          fseen[i] = 1;
          f_k[i] = cyc;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("d16_high",   int'(hi16),  e_high[0]);
    check("d16_period", int'(per16), e_per[0]);
    check("d16_valid",  int'(v16),   int'(e_valid[0]));
    check("d16_ovf",    int'(ov16),  int'(e_ov[0]));
    check("d16_stuck",  int'(st16),  int'(e_stuck[0]));
    check("d16_level",  int'(lv16),  int'(e_lvl[0]));
    check("d8_high",    int'(hi8),   e_high[1]);
    check("d8_period",  int'(per8),  e_per[1]);
    check("d8_valid",   int'(v8),    int'(e_valid[1]));
    check("d8_ovf",     int'(ov8),   int'(e_ov[1]));
    check("d8_stuck",   int'(st8),   int'(e_stuck[1]));
    check("d8_level",   int'(lv8),   int'(e_lvl[1]));
  end

  task automatic hold(input logic v, input int n);
    pwmIn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  initial begin
    int h, l;
    nRst = 1'b0; pwmIn = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    nRst = 1'b1;

    // Steady 100/300
    repeat (4) pulse(100, 300);
    check("lit_steady_high", int'(hi16), 100);
    check("lit_steady_period", int'(per16), 400);
    check("lit_steady_ovf", int'(ov16), 0);

    // 2-cycle glitch rejected, 3-cycle pulse counted as a period
    hold(1'b1, 100); hold(1'b0, 150); hold(1'b1, 2); hold(1'b0, 148);
    pulse(100, 300);
    check("lit_glitch_high", int'(hi16), 100);
    check("lit_glitch_period", int'(per16), 400);
    hold(1'b1, 100); hold(1'b0, 150); hold(1'b1, 3); hold(1'b0, 147);
    pulse(100, 300);
    check("lit_short_high", int'(hi16), 3);
    check("lit_short_period", int'(per16), 150);

    // Enable dropped mid-HIGH
    hold(1'b1, 50);
    en = 1'b0;
    hold(1'b1, 20);
    check("lit_dis_stuck", int'(st16), 0);
    check("lit_dis_high_held", int'(hi16), 100);
    check("lit_dis_period_held", int'(per16), 400);
    en = 1'b1;
    hold(1'b1, 30); hold(1'b0, 300);
    pulse(100, 300);

    // Async reset mid-LOW
    hold(1'b1, 100); hold(1'b0, 150);
    nRst = 1'b0;
    #1;
    check("lit_rst_high", int'(hi16), 0);
    check("lit_rst_period", int'(per16), 0);
    check("lit_rst_valid", int'(v16), 0);
    check("lit_rst_high8", int'(hi8), 0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    hold(1'b0, 150);

    // Stuck high, then recovery
    repeat (2) pulse(100, 300);
    hold(1'b1, 1100);
    check("lit_stuck", int'(st16), 1);
    check("lit_stuck_level", int'(lv16), 1);
    repeat (3) pulse(100, 300);
    check("lit_recover_stuck", int'(st16), 0);
    check("lit_recover_period", int'(per16), 400);

    // Rise exactly at TIMEOUT
    repeat (3) pulse(100, 900);
    check("lit_edge_period", int'(per16), 1000);
    check("lit_edge_stuck", int'(st16), 0);

    // 8-bit instance: in-range, saturating and timed-out periods
    repeat (3) pulse(50, 200);
    check("lit_d8_period", int'(per8), 250);
    check("lit_d8_high", int'(hi8), 50);
    check("lit_d8_ovf0", int'(ov8), 0);
    repeat (3) pulse(50, 205);
    check("lit_d8_sat_period", int'(per8), 255);
    check("lit_d8_ovf1", int'(ov8), 1);
    pulse(50, 250);
    check("lit_d8_stuck", int'(st8), 1);
    check("lit_d8_stuck_level", int'(lv8), 0);

    // Randomized periods, glitches, enable drops
    for (int k = 0; k < 40; k++) begin
      h = $urandom_range(3, 150);
      l = $urandom_range(3, 150);
      if ($urandom_range(0, 7) == 0) begin
        h = 100;
        l = $urandom_range(890, 910);
      end else if ($urandom_range(0, 5) == 0) begin
        l = $urandom_range(195, 215);
      end
      if ($urandom_range(0, 9) == 0) begin
        en = 1'b0;
        hold(1'b1, h);
        en = 1'b1;
      end else begin
        hold(1'b1, h);
      end
      if (l > 20 && $urandom_range(0, 3) == 0) begin
        hold(1'b0, l / 2);
        hold(1'b1, $urandom_range(1, 2));
        hold(1'b0, l - l / 2);
      end else begin
        hold(1'b0, l);
      end
    end
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
